// File: rtl/conv_tile_sequencer.sv
// conv_tile_sequencer
// Command-driven controller for the 16-lane conv2d MAC tile. It terminates the
// CPU custom-function command/response handshake, decodes the function code
// held in function_id[5:3], and then does one of four things: forwards a
// tile-memory write, clears the accumulators, runs the fixed kernel tap
// sequence with address generation, or reads back one accumulator.
//
// Ports
//   clk, reset                 rising-edge clock, asynchronous active-low reset
//   cmd_valid / cmd_ready      command handshake (accept = valid & ready)
//   cmd_payload_function_id    bits [5:3] carry the function code
//   cmd_payload_inputs_0/1     command operands
//   rsp_valid / rsp_ready      response handshake
//   rsp_payload_outputs_0      response data
//   tile_wr_en, tile_wr_slot   tile-memory write strobe and slot (accept cycle)
//   acc_clear                  clear all accumulators (CLEAR state)
//   mac_en, tap_base, w_addr   per-tap accumulate enable and addresses (MAC)
//   out_sel, out_data          accumulator select and its registered value
//   busy                       high whenever the FSM is not IDLE
module conv_tile_sequencer #(
  parameter int KW         = 3,
  parameter int TAPS       = 9,
  parameter int ROW_STRIDE = 6,
  parameter int W_BASE     = 36,
  parameter int PIPE_LAT   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [9:0]  cmd_payload_function_id,
  input  logic [31:0] cmd_payload_inputs_0,
  input  logic [31:0] cmd_payload_inputs_1,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_payload_outputs_0,
  output logic        tile_wr_en,
  output logic [7:0]  tile_wr_slot,
  output logic        acc_clear,
  output logic        mac_en,
  output logic [7:0]  tap_base,
  output logic [7:0]  w_addr,
  output logic [3:0]  out_sel,
  input  logic [31:0] out_data,
  output logic        busy
);

  localparam int TAP_W = $clog2(TAPS + 1);
  localparam int COL_W = $clog2(KW + 1);
  localparam int DRN_W = $clog2(PIPE_LAT + 1);

  localparam logic [TAP_W-1:0] TAP_LAST = TAP_W'(TAPS - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(KW - 1);
  localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(PIPE_LAT - 1);
  localparam logic [7:0]       STRIDE8  = 8'(ROW_STRIDE);
  localparam logic [7:0]       W_BASE8  = 8'(W_BASE);
  localparam logic [31:0]      TAPS32   = 32'(TAPS);

  localparam logic [2:0] FN_LOAD  = 3'd0;
  localparam logic [2:0] FN_RUN   = 3'd1;
  localparam logic [2:0] FN_READ  = 3'd2;
  localparam logic [2:0] FN_CLEAR = 3'd3;

  typedef enum logic [2:0] {IDLE, CLEAR, MAC, DRAIN, READ, RESP} state_t;

  state_t            state_q;
  logic              rdy_en_q;    // holds cmd_ready low for the first cycle out of reset
  logic              run_q;       // CLEAR belongs to a RUN rather than a bare CLEAR
  logic [TAP_W-1:0]  tap_q;
  logic [COL_W-1:0]  col_q, col_d;
  logic [7:0]        row_q, row_d; // row base address: (k / KW) * ROW_STRIDE
  logic [DRN_W-1:0]  drain_q;
  logic              rsp_valid_q, acc_clear_q, mac_en_q, busy_q;
  logic [31:0]       rsp_data_q;
  logic [7:0]        tap_base_q, w_addr_q;
  logic [3:0]        out_sel_q;

  logic       accept;
  logic [2:0] func;

  assign func         = cmd_payload_function_id[5:3];
  assign cmd_ready    = rdy_en_q & (state_q == IDLE) & ~rsp_valid_q;
  assign accept       = cmd_valid & cmd_ready;
  // The tile write happens in the accept cycle itself, so it cannot be registered.
  assign tile_wr_en   = accept & (func == FN_LOAD);
  assign tile_wr_slot = tile_wr_en ? cmd_payload_inputs_1[7:0] : 8'd0;

  assign rsp_valid             = rsp_valid_q;
  assign rsp_payload_outputs_0 = rsp_data_q;
  assign acc_clear             = acc_clear_q;
  assign mac_en                = mac_en_q;
  assign tap_base              = tap_base_q;
  assign w_addr                = w_addr_q;
  assign out_sel               = out_sel_q;
  assign busy                  = busy_q;

  logic unused_bits;
  assign unused_bits = ^{cmd_payload_function_id[9:6], cmd_payload_function_id[2:0],
                         cmd_payload_inputs_0[31:4], cmd_payload_inputs_1[31:8]};

  // Next tap position: column wraps at KW and bumps the row base by the stride,
  // giving (k / KW) * ROW_STRIDE + (k % KW) without a divider.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    col_d = col_q + 1'b1;
    row_d = row_q;
    if (col_q == COL_LAST) begin
      col_d = '0;
      row_d = row_q + STRIDE8;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      rdy_en_q    <= 1'b0;
      run_q       <= 1'b0;
      tap_q       <= '0;
      col_q       <= '0;
      row_q       <= '0;
      drain_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      acc_clear_q <= 1'b0;
      mac_en_q    <= 1'b0;
      busy_q      <= 1'b0;
      tap_base_q  <= '0;
      w_addr_q    <= '0;
      out_sel_q   <= '0;
    end else begin
      rdy_en_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (accept) begin
            busy_q <= 1'b1;
            case (func)
              FN_RUN: begin
                state_q     <= CLEAR;
                acc_clear_q <= 1'b1;
                run_q       <= 1'b1;
              end
              FN_CLEAR: begin
                state_q     <= CLEAR;
                acc_clear_q <= 1'b1;
                run_q       <= 1'b0;
              end
              FN_READ: begin
                state_q   <= READ;
                out_sel_q <= cmd_payload_inputs_0[3:0];
              end
              default: begin // LOAD and unknown codes answer immediately
                state_q     <= RESP;
                rsp_valid_q <= 1'b1;
                rsp_data_q  <= '0;
              end
            endcase
          end
        end
        CLEAR: begin
          acc_clear_q <= 1'b0;
          if (run_q) begin
            state_q    <= MAC;
            mac_en_q   <= 1'b1;
            tap_q      <= '0;
            col_q      <= '0;
            row_q      <= '0;
            tap_base_q <= '0;
            w_addr_q   <= W_BASE8;
          end else begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= '0;
          end
        end
        MAC: begin
          if (tap_q == TAP_LAST) begin
            state_q    <= DRAIN;
            mac_en_q   <= 1'b0;
            tap_base_q <= '0;
            w_addr_q   <= '0;
            drain_q    <= '0;
          end else begin
            tap_q      <= tap_q + 1'b1;
            col_q      <= col_d;
            row_q      <= row_d;
            tap_base_q <= row_d + 8'(col_d);
            w_addr_q   <= w_addr_q + 8'd1;
          end
        end
        DRAIN: begin
          // Wait out the MAC pipeline so the response implies results are final.
          if (drain_q == DRN_LAST) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= TAPS32;
          end else begin
            drain_q <= drain_q + 1'b1;
          end
        end
        READ: begin
          state_q     <= RESP;
          rsp_valid_q <= 1'b1;
          rsp_data_q  <= out_data;
        end
        RESP: begin
          if (rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            busy_q      <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_tile_sequencer.sv
// Directed bench for conv_tile_sequencer: reset, LOAD (single and back-to-back),
// RUN address sequence and response latency, response backpressure, READ
// against a simple accumulator model, bare CLEAR, an unknown function code,
// and reset in the middle of a RUN.
module tb_conv_tile_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [9:0]  cmd_payload_function_id;
  logic [31:0] cmd_payload_inputs_0;
  logic [31:0] cmd_payload_inputs_1;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_payload_outputs_0;
  logic        tile_wr_en;
  logic [7:0]  tile_wr_slot;
  logic        acc_clear;
  logic        mac_en;
  logic [7:0]  tap_base;
  logic [7:0]  w_addr;
  logic [3:0]  out_sel;
  logic [31:0] out_data;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Accumulator model: each lane reads back as 0x100 + its index.
  assign out_data = 32'h100 + {28'd0, out_sel};

  conv_tile_sequencer dut (
    .clk                     (clk),
    .reset                   (reset),
    .cmd_valid               (cmd_valid),
    .cmd_ready               (cmd_ready),
    .cmd_payload_function_id (cmd_payload_function_id),
    .cmd_payload_inputs_0    (cmd_payload_inputs_0),
    .cmd_payload_inputs_1    (cmd_payload_inputs_1),
    .rsp_valid               (rsp_valid),
    .rsp_ready               (rsp_ready),
    .rsp_payload_outputs_0   (rsp_payload_outputs_0),
    .tile_wr_en              (tile_wr_en),
    .tile_wr_slot            (tile_wr_slot),
    .acc_clear               (acc_clear),
    .mac_en                  (mac_en),
    .tap_base                (tap_base),
    .w_addr                  (w_addr),
    .out_sel                 (out_sel),
    .out_data                (out_data),
    .busy                    (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] f, input logic [31:0] in0, input logic [31:0] in1);
    cmd_payload_function_id = {4'd0, f, 3'd0};
    cmd_payload_inputs_0    = in0;
    cmd_payload_inputs_1    = in1;
    cmd_valid               = 1'b1;
  endtask

  task automatic idle_cmd();
    cmd_valid               = 1'b0;
    cmd_payload_function_id = '0;
    cmd_payload_inputs_0    = '0;
    cmd_payload_inputs_1    = '0;
  endtask

  initial begin
    logic [7:0] exp_base [9];
    logic       seen;
    exp_base = '{8'd0, 8'd1, 8'd2, 8'd6, 8'd7, 8'd8, 8'd12, 8'd13, 8'd14};

    reset     = 1'b0;
    rsp_ready = 1'b1;
    idle_cmd();

    // ---- reset state ----
    #3;
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_busy",      busy,      0);
    repeat (2) tick();
    check("rst_mac_en",    mac_en,    0);
    check("rst_acc_clear", acc_clear, 0);
    check("rst_out_sel",   out_sel,   0);
    reset = 1'b1;
    tick();
    check("post_rst_cmd_ready", cmd_ready, 1);

    // ---- LOAD: write strobe in the accept cycle, response next cycle ----
    send(3'd0, 32'd0, 32'h0000_0003);
    #1;
    check("load_wr_en",   tile_wr_en,   1);
    check("load_wr_slot", tile_wr_slot, 8'd3);
    tick();
    idle_cmd();
    #1;
    check("load_rsp_valid", rsp_valid, 1);
    check("load_payload",   rsp_payload_outputs_0, 0);
    check("load_wr_done",   tile_wr_en, 0);
    check("load_busy",      busy, 1);
    tick();
    check("load_rsp_drop",  rsp_valid, 0);
    check("load_ready_again", cmd_ready, 1);

    // ---- back-to-back LOAD; a held cmd_valid during RESP is ignored ----
    send(3'd0, 32'd0, 32'hFFFF_FF2A);
    #1;
    check("b2b_wr_slot", tile_wr_slot, 8'h2A);
    tick();
    check("b2b_rsp_valid",   rsp_valid, 1);
    check("b2b_not_ready",   cmd_ready, 0);
    check("b2b_no_wr_in_rsp", tile_wr_en, 0);
    idle_cmd();
    tick();
    check("b2b_idle", rsp_valid, 0);

    // ---- RUN with backpressure after completion ----
    send(3'd1, 32'd0, 32'd0);
    tick();
    idle_cmd();
    check("run_acc_clear", acc_clear, 1);
    check("run_no_mac_in_clear", mac_en, 0);
    for (int k = 0; k < 9; k++) begin
      tick();
      check($sformatf("run_mac_en_%0d", k),   mac_en,   1);
      check($sformatf("run_tap_base_%0d", k), tap_base, exp_base[k]);
      check($sformatf("run_w_addr_%0d", k),   w_addr,   8'(36 + k));
      check($sformatf("run_acc_clr_%0d", k),  acc_clear, 0);
    end
    tick();
    check("drain_mac_off",  mac_en,   0);
    check("drain_tap_zero", tap_base, 0);
    check("drain_w_zero",   w_addr,   0);
    check("drain1_no_rsp",  rsp_valid, 0);
    rsp_ready = 1'b0;
    tick();
    check("drain2_no_rsp",  rsp_valid, 0);
    tick();
    check("run_rsp_valid",  rsp_valid, 1);
    check("run_payload",    rsp_payload_outputs_0, 32'd9);
    for (int i = 0; i < 5; i++) begin
      send(3'd0, 32'd0, 32'd5);
      #1;
      check($sformatf("stall_ready_%0d", i), cmd_ready, 0);
      check($sformatf("stall_wr_%0d", i),    tile_wr_en, 0);
      tick();
      idle_cmd();
      check($sformatf("stall_valid_%0d", i), rsp_valid, 1);
      check($sformatf("stall_data_%0d", i),  rsp_payload_outputs_0, 32'd9);
    end
    rsp_ready = 1'b1;
    tick();
    check("run_rsp_done", rsp_valid, 0);
    check("run_busy_off", busy, 0);

    // ---- READ: out_sel from inputs_0[3:0], payload sampled from model ----
    send(3'd2, 32'd7, 32'd0);
    tick();
    idle_cmd();
    check("read_out_sel",   out_sel,   4'd7);
    check("read_no_rsp_yet", rsp_valid, 0);
    tick();
    check("read_rsp_valid", rsp_valid, 1);
    check("read_payload",   rsp_payload_outputs_0, 32'h107);
    tick();
    send(3'd2, 32'h1234_567D, 32'd0);
    tick();
    idle_cmd();
    tick();
    check("read2_payload", rsp_payload_outputs_0, 32'h10D);
    tick();

    // ---- bare CLEAR ----
    send(3'd3, 32'd0, 32'd0);
    tick();
    idle_cmd();
    check("clr_acc_clear", acc_clear, 1);
    check("clr_no_rsp",    rsp_valid, 0);
    tick();
    check("clr_acc_off",   acc_clear, 0);
    check("clr_rsp_valid", rsp_valid, 1);
    check("clr_payload",   rsp_payload_outputs_0, 0);
    check("clr_no_mac",    mac_en, 0);
    tick();

    // ---- unknown func 6 with stray bits outside [5:3] ----
    send(3'd6, 32'd3, 32'd9);
    cmd_payload_function_id = 10'b10_0011_0101;
    #1;
    check("unk_no_wr", tile_wr_en, 0);
    tick();
    idle_cmd();
    check("unk_rsp_valid", rsp_valid, 1);
    check("unk_payload",   rsp_payload_outputs_0, 0);
    check("unk_no_clear",  acc_clear, 0);
    check("unk_no_mac",    mac_en, 0);
    check("unk_out_sel_held", out_sel, 4'hD);
    tick();

    // ---- reset during the fifth MAC cycle aborts the run ----
    send(3'd1, 32'd0, 32'd0);
    tick();
    idle_cmd();
    repeat (5) tick();
    check("abort_tap_base_k4", tap_base, 8'd7);
    reset = 1'b0;
    #1;
    check("abort_mac_en",   mac_en,   0);
    check("abort_tap_base", tap_base, 0);
    check("abort_w_addr",   w_addr,   0);
    check("abort_busy",     busy,     0);
    check("abort_out_sel",  out_sel,  0);
    check("abort_rsp",      rsp_valid, 0);
    check("abort_ready",    cmd_ready, 0);
    tick();
    reset = 1'b1;
    tick();
    check("abort_ready_after", cmd_ready, 1);
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (rsp_valid !== 1'b0) seen = 1'b1;
    end
    check("abort_no_rsp", seen, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
